priority_vector_rebuilder: RTL and testbench

- Receive side of the lowest-set-bit position stream. Upstream repeatedly reports and clears the lowest set bit of an 8-bit vector.
- This block accepts that stream of positions, one per beat, and rebuilds the original bit vector.
- A vector ends with a `last` beat. A `none` flag marks the all-zero vector, because position 0 alone is ambiguous.
- Sits between the encoded-event link and downstream vector consumers. Registered, valid/ready on both sides.

---
 rtl/priority_vector_rebuilder_pkg.sv | 27 ++
 rtl/priority_vector_rebuilder_pos_onehot_decoder.sv | 22 ++
 rtl/priority_vector_rebuilder.sv | 99 +++++++++
 tb/tb_priority_vector_rebuilder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/priority_vector_rebuilder_pkg.sv
// ============================================================================
// Module   : priority_vector_rebuilder_pkg
// Brief    : Shared widths, output-state encoding and position-to-mask helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package priority_vector_rebuilder_pkg;

  localparam int PVR_W  = 8;
  localparam int PVR_PW = $clog2(PVR_W);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [PVR_W-1:0] pos_to_onehot(input logic [PVR_PW-1:0] pos);
    logic [PVR_W-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_vector_rebuilder_pos_onehot_decoder.sv
// ============================================================================
// Module   : pos_onehot_decoder
// Brief    : Combinational bit-position to one-hot mask decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pos_onehot_decoder #(
  parameter int W  = 8,
  parameter int PW = 3
) (
  input  logic [PW-1:0] i_pos,
  output logic [W-1:0]  o_onehot
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bits
    assign o_onehot[gi] = (i_pos == PW'(gi));
  end

endmodule

`default_nettype wire

// File: rtl/priority_vector_rebuilder.sv
// ============================================================================
// Module   : priority_vector_rebuilder
// Brief    : Rebuilds a bit vector from a stream of ascending set-bit positions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module priority_vector_rebuilder
  import priority_vector_rebuilder_pkg::*;
#(
  parameter int W  = PVR_W,
  parameter int PW = PVR_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  input  logic          in_last,
  input  logic          in_none,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_vec,
  output logic          out_err
);

  logic [W-1:0]  w_pos_onehot;
  logic [W-1:0]  w_bit;
  logic          w_accept;
  logic          w_out_fire;
  logic          w_order_err;
  out_state_e    w_state_nxt;

  logic [W-1:0]  r_acc;
  logic          r_err_acc;
  logic          r_first;
  logic [PW-1:0] r_prev_pos;
  logic [W-1:0]  r_out_vec;
  logic          r_out_err;
  out_state_e    r_state;

  pos_onehot_decoder #(
    .W  (W),
    .PW (PW)
  ) u_dec (
    .i_pos    (in_pos),
    .o_onehot (w_pos_onehot)
  );

  assign out_valid  = (r_state == ST_FULL);
  assign out_vec    = r_out_vec;
  assign out_err    = r_out_err;
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_bit      = in_none ? '0 : w_pos_onehot;
  // Positions must strictly increase within a vector; a none beat carries no position.
  assign w_order_err = !r_first && !in_none && (in_pos <= r_prev_pos);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept && in_last) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_out_fire && !(w_accept && in_last)) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_acc      <= '0;
      r_err_acc  <= 1'b0;
      r_first    <= 1'b1;
      r_prev_pos <= '0;
      r_out_vec  <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (in_last) begin
          r_out_vec <= in_none ? '0 : (r_acc | w_pos_onehot);
          r_out_err <= r_err_acc | w_order_err | (in_none && !r_first);
          r_acc     <= '0;
          r_err_acc <= 1'b0;
          r_first   <= 1'b1;
        end else begin
          r_acc   <= r_acc | w_bit;
          r_first <= 1'b0;
          if (!in_none) r_prev_pos <= in_pos;
          if (w_order_err || in_none) r_err_acc <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_priority_vector_rebuilder.sv
// ============================================================================
// Module   : tb_priority_vector_rebuilder
// Brief    : Directed table-driven bench for priority_vector_rebuilder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_priority_vector_rebuilder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_last;
  logic       in_none;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_vec;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  priority_vector_rebuilder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .in_none   (in_none),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_err   (out_err)
  );

  typedef struct {
    string          name;
    int             n;
    logic [3:0][2:0] pos;
    logic [3:0]     none;
    logic [7:0]     exp_vec;
    logic           exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drives one beat, waits (bounded) for in_ready, and returns #1 after the accepting edge.
  task automatic send_beat(input logic [2:0] p, input logic l, input logic n);
    int k;
    in_valid = 1'b1; in_pos = p; in_last = l; in_none = n;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL beat_timeout: in_ready=%0b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_none = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{"asc_4_7",   2, {3'd0, 3'd0, 3'd7, 3'd4}, 4'b0000, 8'h90, 1'b0};
    tbl[1] = '{"none_only", 1, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 8'h00, 1'b0};
    tbl[2] = '{"dup_3_3",   2, {3'd0, 3'd0, 3'd3, 3'd3}, 4'b0000, 8'h08, 1'b1};
    tbl[3] = '{"desc_6_2",  2, {3'd0, 3'd0, 3'd2, 3'd6}, 4'b0000, 8'h44, 1'b1};
    tbl[4] = '{"single_0",  1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 8'h01, 1'b0};
    tbl[5] = '{"asc_0to3",  4, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 8'h0F, 1'b0};
    tbl[6] = '{"late_none", 2, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0010, 8'h00, 1'b1};
    tbl[7] = '{"mid_none",  3, {3'd0, 3'd5, 3'd0, 3'd2}, 4'b0010, 8'h24, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_pos = '0; in_last = 1'b0; in_none = 1'b0;
    out_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec",   32'(out_vec),   32'h00);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < tbl[i].n; b++)
        send_beat(tbl[i].pos[b], (b == tbl[i].n - 1), tbl[i].none[b]);
      chk({tbl[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({tbl[i].name, "_vec"},   32'(out_vec),   32'(tbl[i].exp_vec));
      chk({tbl[i].name, "_err"},   32'(out_err),   32'(tbl[i].exp_err));
      tick;
      chk({tbl[i].name, "_valid_drop"}, 32'(out_valid), 32'd0);
    end

    // Backpressure: output held, further beat stalled until the handshake cycle.
    out_ready = 1'b0;
    send_beat(3'd3, 1'b1, 1'b0);
    in_valid = 1'b1; in_pos = 3'd1; in_last = 1'b0; in_none = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_vec", 32'(out_vec),  32'h08);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    send_beat(3'd4, 1'b1, 1'b0);
    chk("bp_next_vec", 32'(out_vec), 32'h12);
    chk("bp_next_err", 32'(out_err), 32'd0);
    tick;

    // Back-to-back single-beat vectors.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pos = 3'(i); in_last = 1'b1; in_none = 1'b0;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      tick;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_vec",   32'(out_vec),   32'(8'h01 << i));
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    // Reset mid-vector discards the partial accumulation.
    send_beat(3'd1, 1'b0, 1'b0);
    send_beat(3'd2, 1'b0, 1'b0);
    reset = 1'b1; tick; reset = 1'b0;
    send_beat(3'd5, 1'b1, 1'b0);
    chk("rstmid_vec", 32'(out_vec), 32'h20);
    chk("rstmid_err", 32'(out_err), 32'd0);
    tick;

    // Reset while the output is pending drops it.
    out_ready = 1'b0;
    send_beat(3'd6, 1'b1, 1'b0);
    chk("rstfull_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("rstfull_valid", 32'(out_valid), 32'd0);
    chk("rstfull_vec",   32'(out_vec),   32'h00);
    out_ready = 1'b1;

    // Nine beats overrun the width and must trip the order check.
    for (int i = 0; i < 8; i++) send_beat(3'(i), 1'b0, 1'b0);
    send_beat(3'd7, 1'b1, 1'b0);
    chk("overrun_vec", 32'(out_vec), 32'hFF);
    chk("overrun_err", 32'(out_err), 32'd1);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
